// File: rtl/lcd_seq_pkg.sv
// Shared types, command bytes and byte-select helpers for the LCD text sequencer.
package lcd_seq_pkg;

   typedef enum logic [1:0] {StPwrup, StInit, StIdle, StFrame} seq_state_e;
   typedef enum logic [1:0] {PhSetup, PhEhigh, PhWait} wr_phase_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_wr_t;

   localparam logic [7:0] CMD_FUNC    = 8'h38;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_DISP_ON = 8'h0C;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_LINE1   = 8'h80;
   localparam logic [7:0] CMD_LINE2   = 8'hC0;

   localparam int unsigned INIT_LEN  = 7;
   localparam int unsigned FRAME_LEN = 34;
   localparam int unsigned CNT_W     = 20;
   localparam int unsigned STEP_W    = 6;

   // Init command for write index 0..6.
   function automatic lcd_wr_t init_write(input logic [STEP_W-1:0] idx);
      lcd_wr_t w;
      w.rs = 1'b0;
      case (idx)
         6'd0, 6'd1, 6'd2, 6'd3: w.data = CMD_FUNC;
         6'd4:                   w.data = CMD_ENTRY;
         6'd5:                   w.data = CMD_DISP_ON;
         default:                w.data = CMD_CLEAR;
      endcase
      return w;
   endfunction

   // Character idx (1..32) of a frame; char 1 sits in the top byte.
   function automatic logic [7:0] char_at(input logic [255:0] frame,
                                          input logic [STEP_W-1:0] idx);
      logic [7:0] pos;
      pos = {2'b00, 6'd32 - idx} << 3;
      return frame[pos +: 8];
   endfunction

   // Frame write for index 0..33: LINE1, chars 1-16, LINE2, chars 17-32.
   function automatic lcd_wr_t frame_write(input logic [255:0] frame,
                                           input logic [STEP_W-1:0] idx);
      lcd_wr_t w;
      if (idx == 6'd0) begin
         w = '{rs: 1'b0, data: CMD_LINE1};
      end else if (idx < 6'd17) begin
         w = '{rs: 1'b1, data: char_at(frame, idx)};
      end else if (idx == 6'd17) begin
         w = '{rs: 1'b0, data: CMD_LINE2};
      end else begin
         w = '{rs: 1'b1, data: char_at(frame, idx - 6'd1)};
      end
      return w;
   endfunction

endpackage

// File: rtl/lcd_write_phy.sv
// Single LCD write engine: SETUP (E low), EHIGH (E high), WAIT (E low), rs/data held throughout.
// A start on the done cycle chains the next write with no gap.
module lcd_write_phy
   import lcd_seq_pkg::*;
#(
   parameter int unsigned T_SETUP  = 4,
   parameter int unsigned T_E_HIGH = 12,
   parameter int unsigned T_CMD    = 2000,
   parameter int unsigned T_CLEAR  = 82000
) (
   input  logic       board_clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       is_clear,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       done
);

   logic             active_q, active_d;
   wr_phase_e        phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             clear_q, clear_d;
   logic             e_q, e_d;

   assign done     = active_q && (phase_q == PhWait) && (cnt_q == '0);
   assign lcd_e    = e_q;
   assign lcd_rs   = rs_q;
   assign lcd_data = data_q;

   // Phase sequencing; each phase counts down to zero before advancing.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      rs_d     = rs_q;
      data_d   = data_q;
      clear_d  = clear_q;
      if (start && (!active_q || done)) begin
         active_d = 1'b1;
         phase_d  = PhSetup;
         cnt_d    = CNT_W'(T_SETUP - 1);
         rs_d     = rs;
         data_d   = data;
         clear_d  = is_clear;
      end else if (active_q) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            unique case (phase_q)
               PhSetup: begin
                  phase_d = PhEhigh;
                  cnt_d   = CNT_W'(T_E_HIGH - 1);
               end
               PhEhigh: begin
                  phase_d = PhWait;
                  cnt_d   = clear_q ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);
               end
               default: active_d = 1'b0;
            endcase
         end
      end
      e_d = active_d && (phase_d == PhEhigh);
   end

   // Phase registers; E is registered so it never glitches.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         active_q <= 1'b0;
         phase_q  <= PhSetup;
         cnt_q    <= '0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         clear_q  <= 1'b0;
         e_q      <= 1'b0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         clear_q  <= clear_d;
         e_q      <= e_d;
      end
   end

endmodule

// File: rtl/lcd_text_sequencer.sv
// Character LCD driver: power-up wait, init commands, then whole-frame rewrites from a
// snapshot of the 32-char text whenever it changes or a refresh is requested.
module lcd_text_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_SETUP   = 4,
   parameter int unsigned T_E_HIGH  = 12,
   parameter int unsigned T_CMD     = 2000,
   parameter int unsigned T_CLEAR   = 82000
) (
   input  logic         board_clk,
   input  logic         Reset,
   input  logic [255:0] text_in,
   input  logic         refresh_req,
   output logic [7:0]   lcd_data,
   output logic         lcd_e,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_bl,
   output logic         busy,
   output logic         frame_done
);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  pwr_cnt_q, pwr_cnt_d;
   logic [STEP_W-1:0] step_q, step_d, next_idx;
   logic [255:0]      shadow_q, shadow_d;
   logic              pending_q, pending_d;
   logic              frame_done_q, frame_done_d;
   logic              wr_start, wr_done, wr_is_clear;
   lcd_wr_t           wr;

   assign lcd_rw      = 1'b0;
   assign lcd_bl      = 1'b0;
   assign busy        = (state_q != StIdle);
   assign frame_done  = frame_done_q;
   assign next_idx    = step_q + 6'd1;
   assign wr_is_clear = !wr.rs && (wr.data == CMD_CLEAR);

   // Sequencer: picks the next write and issues it on the previous write's done cycle.
   always_comb begin
      state_d      = state_q;
      pwr_cnt_d    = pwr_cnt_q;
      step_d       = step_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;
      wr_start     = 1'b0;
      wr           = frame_write(shadow_q, next_idx);
      unique case (state_q)
         StPwrup: begin
            wr = init_write(6'd0);
            if (pwr_cnt_q == '0) begin
               wr_start = 1'b1;
               step_d   = '0;
               state_d  = StInit;
            end else begin
               pwr_cnt_d = pwr_cnt_q - 1'b1;
            end
         end
         StInit: begin
            wr = init_write(next_idx);
            if (wr_done) begin
               if (step_q == STEP_W'(INIT_LEN - 1)) begin
                  state_d      = StIdle;
                  frame_done_d = 1'b1;
               end else begin
                  wr_start = 1'b1;
                  step_d   = next_idx;
               end
            end
         end
         StIdle: begin
            wr = frame_write(shadow_q, 6'd0);
            if (pending_q || refresh_req || (text_in != shadow_q)) begin
               wr_start  = 1'b1;
               step_d    = '0;
               shadow_d  = text_in;
               pending_d = 1'b0;
               state_d   = StFrame;
            end
         end
         default: begin
            // Text changes mid-frame are caught by the IDLE compare; refreshes must be latched.
            if (refresh_req) begin
               pending_d = 1'b1;
            end
            if (wr_done) begin
               if (step_q == STEP_W'(FRAME_LEN - 1)) begin
                  state_d      = StIdle;
                  frame_done_d = 1'b1;
               end else begin
                  wr_start = 1'b1;
                  step_d   = next_idx;
               end
            end
         end
      endcase
   end

   // Sequencer state; reset replays the whole power-up and init.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= StPwrup;
         pwr_cnt_q    <= CNT_W'(T_POWERUP - 1);
         step_q       <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pwr_cnt_q    <= pwr_cnt_d;
         step_q       <= step_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
      end
   end

   lcd_write_phy #(
      .T_SETUP  (T_SETUP),
      .T_E_HIGH (T_E_HIGH),
      .T_CMD    (T_CMD),
      .T_CLEAR  (T_CLEAR)
   ) u_phy (
      .board_clk (board_clk),
      .Reset     (Reset),
      .start     (wr_start),
      .rs        (wr.rs),
      .data      (wr.data),
      .is_clear  (wr_is_clear),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_data  (lcd_data),
      .done      (wr_done)
   );

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer with shortened timing parameters.
module tb_lcd_text_sequencer;

   logic         board_clk = 1'b0;
   logic         Reset = 1'b1;
   logic [255:0] text_in;
   logic         refresh_req;
   logic [7:0]   lcd_data;
   logic         lcd_e, lcd_rs, lcd_rw, lcd_bl, busy, frame_done;

   lcd_text_sequencer #(
      .T_POWERUP (20),
      .T_SETUP   (2),
      .T_E_HIGH  (3),
      .T_CMD     (5),
      .T_CLEAR   (10)
   ) dut (
      .board_clk   (board_clk),
      .Reset       (Reset),
      .text_in     (text_in),
      .refresh_req (refresh_req),
      .lcd_data    (lcd_data),
      .lcd_e       (lcd_e),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_bl      (lcd_bl),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 board_clk = ~board_clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Cycle count since Reset release (edge n after release reads n).
   int cyc = 0;
   initial forever begin
      @(posedge board_clk);
      if (Reset) cyc = 0;
      else cyc++;
   end

   // Write monitor: logs {rs,data} at each E rise, tracks E width and bus stability.
   logic [8:0] wr_q[$];
   int   n_rises = 0, n_done = 0, bad_elen = 0, unstable = 0, e_len = 0;
   logic e_prev = 1'b0;
   logic [8:0] e_val = '0;
   initial forever begin
      @(negedge board_clk);
      if (lcd_e && !e_prev) begin
         wr_q.push_back({lcd_rs, lcd_data});
         n_rises++;
         e_len = 1;
         e_val = {lcd_rs, lcd_data};
      end else if (lcd_e) begin
         e_len++;
         if ({lcd_rs, lcd_data} != e_val) unstable++;
      end else if (e_prev) begin
         if (e_len != 3) bad_elen++;
      end
      if (frame_done) n_done++;
      e_prev = lcd_e;
   end

   task automatic step();
      @(negedge board_clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int budget, output int at);
      logic seen = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (frame_done) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      check({tag, " frame_done seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_writes(input string tag, input int n, input int budget);
      logic seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (wr_q.size() >= n) seen = 1'b1;
      end
      check({tag, " writes reached"}, 32'(seen), 32'd1);
   endtask

   task automatic pulse_refresh();
      refresh_req = 1'b1;
      step();
      refresh_req = 1'b0;
   endtask

   task automatic check_init(input string tag);
      logic [7:0] cmds [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h06, 8'h0C, 8'h01};
      check({tag, " count"}, 32'(wr_q.size()), 32'd7);
      for (int i = 0; i < 7 && i < wr_q.size(); i++)
         check($sformatf("%s cmd%0d", tag, i), 32'(wr_q[i]), {23'd0, 1'b0, cmds[i]});
   endtask

   task automatic check_frame(input string tag, input logic [255:0] txt);
      logic [8:0] exp [34];
      exp[0]  = {1'b0, 8'h80};
      exp[17] = {1'b0, 8'hC0};
      for (int i = 0; i < 16; i++) begin
         exp[1 + i]  = {1'b1, txt[255 - 8 * i -: 8]};
         exp[18 + i] = {1'b1, txt[127 - 8 * i -: 8]};
      end
      check({tag, " count"}, 32'(wr_q.size()), 32'd34);
      for (int i = 0; i < 34 && i < wr_q.size(); i++)
         check($sformatf("%s wr%0d", tag, i), 32'(wr_q[i]), 32'(exp[i]));
   endtask

   initial begin
      int t, fs, nr, nd;
      logic [255:0] old_text;
      text_in     = {32{8'h20}};
      refresh_req = 1'b0;
      Reset       = 1'b1;
      repeat (3) step();

      // Reset values
      check("rst lcd_data", 32'(lcd_data), 32'h00);
      check("rst lcd_e", 32'(lcd_e), 32'd0);
      check("rst lcd_rs", 32'(lcd_rs), 32'd0);
      check("rst lcd_rw", 32'(lcd_rw), 32'd0);
      check("rst lcd_bl", 32'(lcd_bl), 32'd0);
      check("rst busy", 32'(busy), 32'd1);
      check("rst frame_done", 32'(frame_done), 32'd0);

      // Init then first frame of spaces
      Reset = 1'b0;
      wait_done("init", 200, t);
      check("init done cycle", 32'(t), 32'd95);
      check_init("init");
      wr_q.delete();
      step();
      check("frame1 start data", 32'(lcd_data), 32'h80);
      check("frame1 start rs", 32'(lcd_rs), 32'd0);
      check("frame1 start e", 32'(lcd_e), 32'd0);
      fs = cyc;
      wait_done("frame1", 400, t);
      check("frame1 length", 32'(t - fs), 32'd340);
      check_frame("frame1", text_in);
      wr_q.delete();

      // Quiet IDLE
      nr = n_rises;
      nd = n_done;
      repeat (1000) step();
      check("idle no E", 32'(n_rises), 32'(nr));
      check("idle no done", 32'(n_done), 32'(nd));
      check("idle busy", 32'(busy), 32'd0);

      // Text change in IDLE
      text_in[255:248] = 8'h41;
      step();
      check("change start data", 32'(lcd_data), 32'h80);
      check("change busy", 32'(busy), 32'd1);
      wait_done("change", 400, t);
      if (wr_q.size() > 1) check("change wr1", 32'(wr_q[1]), {23'd0, 1'b1, 8'h41});
      check_frame("change", text_in);
      check("E width 3", 32'(bad_elen), 32'd0);
      check("bus stable under E", 32'(unstable), 32'd0);
      wr_q.delete();

      // Text change during write 3
      pulse_refresh();
      wait_writes("mid", 3, 100);
      old_text = text_in;
      text_in[223:216] = 8'h42;
      wait_done("mid old", 400, t);
      check_frame("mid old", old_text);
      wr_q.delete();
      step();
      check("mid restart data", 32'(lcd_data), 32'h80);
      check("mid restart busy", 32'(busy), 32'd1);
      wait_done("mid new", 400, t);
      check_frame("mid new", text_in);
      wr_q.delete();

      // Forced refresh with unchanged text
      nd = n_done;
      pulse_refresh();
      wait_done("refresh", 400, t);
      check_frame("refresh", text_in);
      repeat (200) step();
      check("refresh total writes", 32'(wr_q.size()), 32'd34);
      check("refresh done pulses", 32'(n_done - nd), 32'd1);
      wr_q.delete();

      // Reset while E high on a character write
      pulse_refresh();
      wait_writes("rst mid", 2, 100);
      check("rst mid e before", 32'(lcd_e), 32'd1);
      Reset = 1'b1;
      #1;
      check("rst mid lcd_e", 32'(lcd_e), 32'd0);
      check("rst mid lcd_rs", 32'(lcd_rs), 32'd0);
      check("rst mid lcd_data", 32'(lcd_data), 32'h00);
      check("rst mid busy", 32'(busy), 32'd1);
      repeat (3) step();
      Reset = 1'b0;
      wr_q.delete();
      wait_done("replay", 200, t);
      check("replay done cycle", 32'(t), 32'd95);
      check_init("replay");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_text_sequencer.md
# lcd_text_sequencer

Drives the character LCD panel directly from the calculator's 32-character text frame (two lines of 16 ASCII bytes). After reset it runs the panel power-up and initialisation sequence, then rewrites the whole frame whenever the text changes or a refresh is requested. A snapshot of the text is taken at the start of each frame so the panel never shows a torn frame. It sits between the calculator core's text output and the LCD pins, running on board_clk.

## Interface
- T_POWERUP, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- T_SETUP, 4: cycles that RS/data are stable before E rises.
- T_E_HIGH, 12: cycles E is held high.
- T_CMD, 2000: wait cycles after E falls, for every write except clear (40 us).
- T_CLEAR, 82000: wait cycles after E falls for the clear command 0x01 (1.64 ms).
- board_clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- text_in  in  256  frame text; char 1 (line 1, column 1) is [255:248], char 32 is [7:0].
- refresh_req  in  1  single-cycle pulse; forces a full frame rewrite.
- lcd_data  out  8  panel data bus (8-bit mode).
- lcd_e  out  1  panel enable strobe.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  tied 0 (write only).
- lcd_bl  out  1  tied 0.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame (or the init phase) completes.

## Operation
- **Reset values:** lcd_data = 0x00, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_bl = 0, busy = 1, frame_done = 0. State is PWRUP, the shadow register is cleared and the pending flag is set.
- **States:** PWRUP → INIT → IDLE ↔ FRAME.
- **PWRUP:** count T_POWERUP cycles, then go to INIT.
- **INIT:** issue commands in this order, all with rs = 0: 0x38, 0x38, 0x38, 0x38, 0x06, 0x0C, 0x01. Then go to IDLE, with pending still set.
- **IDLE:** start a frame when pending = 1, or refresh_req = 1, or text_in ≠ shadow.
  - On the start cycle: shadow ← text_in, pending ← 0, state ← FRAME.
- **FRAME:** 34 writes in this order:
  - 0x80 (rs = 0);
  - chars 1–16 (rs = 1);
  - 0xC0 (rs = 0);
  - chars 17–32 (rs = 1).
  - All character bytes come from shadow, never from text_in.
- **During a frame:**
  - refresh_req sets pending.
  - Changes to text_in are ignored; they are caught by the comparison on return to IDLE.
- **Write engine:** a single write runs SETUP (E = 0, rs/data driven), then EHIGH (E = 1), then WAIT (E = 0, rs/data held). WAIT uses T_CLEAR for data 0x01 with rs = 0, and T_CMD for everything else.
- **frame_done:** pulses on the cycle the last WAIT of INIT or FRAME completes, as the state enters IDLE.
- **Back-to-back frames:** if a start condition already holds on entry to IDLE, the next frame starts on the following cycle.

## Timing
- A write costs T_SETUP + T_E_HIGH + T_wait cycles.
- The next write's data appears on the cycle after the previous WAIT ends.
- Frame start latency: the start condition is sampled in IDLE, and on the next cycle lcd_data = 0x80, rs = 0, E = 0.
- E rising edge: T_SETUP cycles after data is valid. E falling edge: T_E_HIGH cycles after the rise. rs and data never change while E = 1.
- Init length = T_POWERUP + 6·(T_SETUP + T_E_HIGH + T_CMD) + (T_SETUP + T_E_HIGH + T_CLEAR).
- Frame length = 34·(T_SETUP + T_E_HIGH + T_CMD).
- Reset mid-write, including with E high: all outputs return to their reset values asynchronously, and the full PWRUP + INIT sequence replays after release.
- All counters are sized for the largest parameter (T_POWERUP needs 20 bits). Counters count down and never wrap.

## Structure
- **Package lcd_seq_pkg:** the state enum (PWRUP, INIT, IDLE, FRAME); the write-phase enum (SETUP, EHIGH, WAIT); command constants CMD_FUNC = 0x38, CMD_ENTRY = 0x06, CMD_DISP_ON = 0x0C, CMD_CLEAR = 0x01, CMD_LINE1 = 0x80, CMD_LINE2 = 0xC0; INIT_LEN = 7; FRAME_LEN = 34.
- **Sub-module lcd_write_phy:** the single-write engine.
  - Inputs: start, rs, data[7:0], is_clear.
  - Outputs: lcd_e, lcd_rs, lcd_data, done.
  - Owns the phase counter.
- **Top level:** owns the state machine, the step index (0–33), shadow, pending and the byte-select mux.

## Test plan
Parameters for the bench: T_POWERUP = 20, T_SETUP = 2, T_E_HIGH = 3, T_CMD = 5, T_CLEAR = 10. A normal write therefore takes 10 cycles.

- **Init plus first frame:** release Reset with text_in all 0x20 → command bytes 38, 38, 38, 38, 06, 0C, 01 with rs = 0, and frame_done at cycle 95. The first frame follows: 80, 16×20 (rs = 1), C0, 16×20, then frame_done 340 cycles later.
- **No spurious writes:** IDLE with text_in stable for 1000 cycles → no E pulses, busy = 0.
- **Text change:** set char 1 to 0x41 in IDLE → frame starts the next cycle; the second write is data 0x41 with rs = 1, and E is high for exactly 3 cycles.
- **Change mid-frame:** change char 5 to 0x42 during write 3 → the current frame completes with 0x20 in position 5; after frame_done a second frame starts on the next cycle carrying 0x42.
- **Forced refresh:** refresh_req pulse in IDLE with unchanged text → exactly one frame of 34 writes, then one frame_done.
- **Reset mid-write:** assert Reset while E = 1 → lcd_e, lcd_rs and lcd_data go to 0 immediately and busy = 1; after release, the full init replays and frame_done occurs at cycle 95.
